// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM (IF/ID/EX/MEM/WB) with cycle and instruction counters.
// Latency: j/NOP 2, beq/bne 3, ALU and sw 4, lw 5 cycles, plus fetch and memory wait cycles.
// Backpressure: stalls in IF until Inst_Ready and in MEM until Mem_Ready; readies seen in other states are ignored.
module multi_cycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instruction,
    input  logic        Inst_Ready,
    input  logic        Mem_Ready,
    input  logic        Zero,
    output logic        Inst_Req,
    output logic        IR_write,
    output logic        PC_write,
    output logic        RF_wen,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        ALU_srcA_shamt,
    output logic        ALU_srcB_imm,
    output logic        Imm_zext,
    output logic        RegDst_rt,
    output logic [11:0] ALUop,
    output logic [31:0] cycle_cnt,
    output logic [31:0] inst_cnt
);

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;

    // Instruction class decides the path through EX/MEM/WB.
    typedef enum logic [2:0] {C_NOP, C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_J} cls_t;

    typedef struct packed {
        cls_t        cls;
        logic [11:0] aluop;
        logic        shamt;
        logic        imm;
        logic        zext;
        logic        rt;
    } dec_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_op;
    logic [5:0]  r_funct;
    dec_t        r_dec;
    dec_t        w_dec;
    logic        w_inst_done;
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_inst_cnt;

    // Only opcode and funct steer control; the register/immediate fields belong to the datapath.
    logic w_unused_fields;
    assign w_unused_fields = ^Instruction[25:6];

    assign cycle_cnt = r_cycle_cnt;
    assign inst_cnt  = r_inst_cnt;

    // Decode the latched opcode/funct into class, one-hot ALU op and operand selects.
    always_comb begin
        w_dec = '0;
        case (r_op)
            6'h00: begin
                w_dec.cls = C_ALU;
                case (r_funct)
                    6'h21:   w_dec.aluop = 12'h001;
                    6'h23:   w_dec.aluop = 12'h002;
                    6'h24:   w_dec.aluop = 12'h004;
                    6'h25:   w_dec.aluop = 12'h008;
                    6'h27:   w_dec.aluop = 12'h010;
                    6'h26:   w_dec.aluop = 12'h020;
                    6'h2a:   w_dec.aluop = 12'h040;
                    6'h2b:   w_dec.aluop = 12'h080;
                    6'h00:   begin w_dec.aluop = 12'h100; w_dec.shamt = 1'b1; end
                    6'h02:   begin w_dec.aluop = 12'h200; w_dec.shamt = 1'b1; end
                    6'h03:   begin w_dec.aluop = 12'h400; w_dec.shamt = 1'b1; end
                    default: w_dec.cls = C_NOP;
                endcase
            end
            6'h02: w_dec.cls = C_J;
            6'h09: begin w_dec.cls = C_ALU; w_dec.aluop = 12'h001; w_dec.imm = 1'b1; w_dec.rt = 1'b1; end
            6'h0c: begin w_dec.cls = C_ALU; w_dec.aluop = 12'h004; w_dec.imm = 1'b1; w_dec.rt = 1'b1; w_dec.zext = 1'b1; end
            6'h0d: begin w_dec.cls = C_ALU; w_dec.aluop = 12'h008; w_dec.imm = 1'b1; w_dec.rt = 1'b1; w_dec.zext = 1'b1; end
            6'h0e: begin w_dec.cls = C_ALU; w_dec.aluop = 12'h020; w_dec.imm = 1'b1; w_dec.rt = 1'b1; w_dec.zext = 1'b1; end
            6'h0a: begin w_dec.cls = C_ALU; w_dec.aluop = 12'h040; w_dec.imm = 1'b1; w_dec.rt = 1'b1; end
            6'h0b: begin w_dec.cls = C_ALU; w_dec.aluop = 12'h080; w_dec.imm = 1'b1; w_dec.rt = 1'b1; end
            6'h0f: begin w_dec.cls = C_ALU; w_dec.aluop = 12'h800; w_dec.imm = 1'b1; w_dec.rt = 1'b1; end
            6'h23: begin w_dec.cls = C_LW;  w_dec.aluop = 12'h001; w_dec.imm = 1'b1; w_dec.rt = 1'b1; end
            6'h2b: begin w_dec.cls = C_SW;  w_dec.aluop = 12'h001; w_dec.imm = 1'b1; end
            6'h04: begin w_dec.cls = C_BEQ; w_dec.aluop = 12'h002; end
            6'h05: begin w_dec.cls = C_BNE; w_dec.aluop = 12'h002; end
            default: w_dec = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IF;
        else     r_state <= w_next;
    end

    // Capture opcode/funct when the fetch completes in IF.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= 6'h00;
            r_funct <= 6'h00;
        end else if (r_state == S_IF && Inst_Ready) begin
            r_op    <= Instruction[31:26];
            r_funct <= Instruction[5:0];
        end
    end

    // Register the decode word at the end of ID so EX/MEM/WB see a stable copy.
    always_ff @(posedge clk) begin
        if (rst)                  r_dec <= '0;
        else if (r_state == S_ID) r_dec <= w_dec;
    end

    // Performance counters; both wrap naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt <= 32'd0;
            r_inst_cnt  <= 32'd0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_inst_done) r_inst_cnt <= r_inst_cnt + 32'd1;
        end
    end

    // Next state and all strobes; reset forces every output low regardless of the current state.
    always_comb begin
        w_next         = r_state;
        w_inst_done    = 1'b0;
        Inst_Req       = 1'b0;
        IR_write       = 1'b0;
        PC_write       = 1'b0;
        RF_wen         = 1'b0;
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        ALU_srcA_shamt = 1'b0;
        ALU_srcB_imm   = 1'b0;
        Imm_zext       = 1'b0;
        RegDst_rt      = 1'b0;
        ALUop          = 12'h000;
        if (!rst) begin
            // Selects stay driven from the decode word for the rest of the instruction.
            if (r_state == S_EX || r_state == S_MEM || r_state == S_WB) begin
                ALU_srcA_shamt = r_dec.shamt;
                ALU_srcB_imm   = r_dec.imm;
                Imm_zext       = r_dec.zext;
                RegDst_rt      = r_dec.rt;
            end
            case (r_state)
                S_IF: begin
                    Inst_Req = 1'b1;
                    if (Inst_Ready) begin
                        IR_write = 1'b1;
                        PC_write = 1'b1;
                        w_next   = S_ID;
                    end
                end
                S_ID: begin
                    if (w_dec.cls == C_J) begin
                        PC_write    = 1'b1;
                        w_next      = S_IF;
                        w_inst_done = 1'b1;
                    end else if (w_dec.cls == C_NOP) begin
                        w_next      = S_IF;
                        w_inst_done = 1'b1;
                    end else begin
                        w_next = S_EX;
                    end
                end
                S_EX: begin
                    ALUop = r_dec.aluop;
                    case (r_dec.cls)
                        C_ALU:       w_next = S_WB;
                        C_LW, C_SW:  w_next = S_MEM;
                        C_BEQ: begin
                            PC_write    = Zero;
                            w_next      = S_IF;
                            w_inst_done = 1'b1;
                        end
                        C_BNE: begin
                            PC_write    = ~Zero;
                            w_next      = S_IF;
                            w_inst_done = 1'b1;
                        end
                        default: begin
                            w_next      = S_IF;
                            w_inst_done = 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    MemRead  = (r_dec.cls == C_LW);
                    MemWrite = (r_dec.cls == C_SW);
                    if (Mem_Ready) begin
                        if (r_dec.cls == C_LW) begin
                            w_next = S_WB;
                        end else begin
                            w_next      = S_IF;
                            w_inst_done = 1'b1;
                        end
                    end
                end
                S_WB: begin
                    RF_wen      = 1'b1;
                    w_next      = S_IF;
                    w_inst_done = 1'b1;
                end
                default: w_next = S_IF;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized bench for multi_cycle_ctrl against an instruction-level reference model.
// Latency: the model derives the expected phase sequence of each instruction from its class and wait counts.
// Backpressure: fetch and memory waits are randomized; stray readies are injected outside their states.
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Instruction;
    logic        Inst_Ready, Mem_Ready, Zero;
    logic        Inst_Req, IR_write, PC_write, RF_wen, MemRead, MemWrite;
    logic        ALU_srcA_shamt, ALU_srcB_imm, Imm_zext, RegDst_rt;
    logic [11:0] ALUop;
    logic [31:0] cycle_cnt, inst_cnt;

    always #5 clk = ~clk;

    multi_cycle_ctrl dut (
        .clk(clk), .rst(rst), .Instruction(Instruction), .Inst_Ready(Inst_Ready),
        .Mem_Ready(Mem_Ready), .Zero(Zero), .Inst_Req(Inst_Req), .IR_write(IR_write),
        .PC_write(PC_write), .RF_wen(RF_wen), .MemRead(MemRead), .MemWrite(MemWrite),
        .ALU_srcA_shamt(ALU_srcA_shamt), .ALU_srcB_imm(ALU_srcB_imm), .Imm_zext(Imm_zext),
        .RegDst_rt(RegDst_rt), .ALUop(ALUop), .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
    );

    typedef enum {K_NOP, K_ALU, K_LW, K_SW, K_BEQ, K_BNE, K_J} kind_e;

    // Supported encodings and the ALUop bit each selects.
    logic [5:0] r_funct_tbl [11] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h27, 6'h26, 6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03};
    int         r_bit_tbl   [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    logic [5:0] i_op_tbl    [11] = '{6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h0b, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05};
    int         i_bit_tbl   [11] = '{0, 2, 3, 5, 6, 7, 11, 0, 0, 1, 1};
    logic [5:0] bad_op_tbl  [5]  = '{6'h01, 6'h08, 6'h10, 6'h20, 6'h3f};
    logic [5:0] bad_fn_tbl  [4]  = '{6'h08, 6'h20, 6'h22, 6'h1a};

    int          n_cmp, n_err;
    logic [31:0] m_cyc, m_insts;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [17:0] strobes(input logic iq, input logic irw, input logic pcw,
                                            input logic rf, input logic mr, input logic mw,
                                            input logic [11:0] alu);
        return {iq, irw, pcw, rf, mr, mw, alu};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Instruction-level model: class, one-hot ALU op, selects {shamt, imm, zext, rt}.
    function automatic void ref_decode(input logic [31:0] ins, output kind_e k,
                                       output logic [11:0] alu, output logic [3:0] sel);
        logic [5:0] op;
        logic [5:0] fn;
        op  = ins[31:26];
        fn  = ins[5:0];
        k   = K_NOP;
        alu = 12'h000;
        sel = 4'b0000;
        if (op == 6'h00) begin
            for (int i = 0; i < 11; i++)
                if (fn == r_funct_tbl[i]) begin
                    k      = K_ALU;
                    alu    = 12'd1 << r_bit_tbl[i];
                    sel[3] = (r_bit_tbl[i] >= 8);
                end
        end else if (op == 6'h02) begin
            k = K_J;
        end else begin
            for (int i = 0; i < 11; i++)
                if (op == i_op_tbl[i]) begin
                    alu = 12'd1 << i_bit_tbl[i];
                    k   = (op == 6'h23) ? K_LW : (op == 6'h2b) ? K_SW :
                          (op == 6'h04) ? K_BEQ : (op == 6'h05) ? K_BNE : K_ALU;
                    sel[2] = (k != K_BEQ && k != K_BNE);
                    sel[1] = (op == 6'h0c || op == 6'h0d || op == 6'h0e);
                    sel[0] = (k == K_ALU || k == K_LW);
                end
        end
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        int          c;
        w = $urandom;
        c = $urandom_range(0, 5);
        case (c)
            0, 1: begin w[31:26] = 6'h00; w[5:0] = r_funct_tbl[$urandom_range(0, 10)]; end
            2, 3: w[31:26] = i_op_tbl[$urandom_range(0, 10)];
            4:    w[31:26] = 6'h02;
            default: begin
                if (rb()) begin w[31:26] = 6'h00; w[5:0] = bad_fn_tbl[$urandom_range(0, 3)]; end
                else      w[31:26] = bad_op_tbl[$urandom_range(0, 4)];
            end
        endcase
        return w;
    endfunction

    // One clock: drive readies, check outputs mid-cycle, advance the cycle model on the edge.
    // sel_mode: 0 none, 1 all four selects, 2 RegDst_rt only.
    task automatic cyc(input logic ir, input logic mr, input logic [17:0] exp_s,
                       input int sel_mode, input logic [3:0] exp_sel);
        Inst_Ready = ir;
        Mem_Ready  = mr;
        #2;
        check_val("strobes", {Inst_Req, IR_write, PC_write, RF_wen, MemRead, MemWrite, ALUop}, exp_s);
        if (sel_mode == 1)
            check_val("selects", {ALU_srcA_shamt, ALU_srcB_imm, Imm_zext, RegDst_rt}, exp_sel);
        else if (sel_mode == 2)
            check_val("regdst_wb", RegDst_rt, exp_sel[0]);
        check_val("cycle_cnt", cycle_cnt, m_cyc);
        @(posedge clk);
        if (rst) m_cyc = 32'd0;
        else     m_cyc = m_cyc + 32'd1;
        @(negedge clk);
    endtask

    // Runs one instruction from its first IF cycle; rst_mem >= 0 pulses reset in that MEM wait cycle.
    task automatic run_inst(input logic [31:0] inst, input int fw, input int mw,
                            input logic z, input int rst_mem);
        kind_e       k;
        logic [11:0] alu;
        logic [3:0]  sel;
        logic        pcw;
        ref_decode(inst, k, alu, sel);
        Zero = z;
        check_val("inst_cnt", inst_cnt, m_insts);
        for (int i = 0; i <= fw; i++) begin
            Instruction = (i == fw) ? inst : $urandom;
            cyc(i == fw, rb(), strobes(1'b1, i == fw, i == fw, 1'b0, 1'b0, 1'b0, 12'h000), 0, 4'b0);
        end
        Instruction = $urandom;
        cyc(rb(), rb(), strobes(1'b0, 1'b0, k == K_J, 1'b0, 1'b0, 1'b0, 12'h000), 0, 4'b0);
        if (k == K_J || k == K_NOP) begin
            m_insts = m_insts + 32'd1;
            return;
        end
        pcw = (k == K_BEQ) ? z : (k == K_BNE) ? ~z : 1'b0;
        cyc(rb(), rb(), strobes(1'b0, 1'b0, pcw, 1'b0, 1'b0, 1'b0, alu), 1, sel);
        if (k == K_BEQ || k == K_BNE) begin
            m_insts = m_insts + 32'd1;
            return;
        end
        if (k == K_LW || k == K_SW) begin
            for (int j = 0; j <= mw; j++) begin
                if (j == rst_mem) begin
                    rst = 1'b1;
                    cyc(rb(), 1'b1, 18'h0, 1, 4'b0);
                    check_val("inst_cnt_rst", inst_cnt, 32'd0);
                    rst     = 1'b0;
                    m_insts = 32'd0;
                    return;
                end
                cyc(rb(), j == mw, strobes(1'b0, 1'b0, 1'b0, 1'b0, k == K_LW, k == K_SW, 12'h000), 0, 4'b0);
            end
            if (k == K_SW) begin
                m_insts = m_insts + 32'd1;
                return;
            end
        end
        cyc(rb(), rb(), strobes(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000), 2, sel);
        m_insts = m_insts + 32'd1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; m_cyc = 32'd0; m_insts = 32'd0;
        rst = 1'b1; Inst_Ready = 1'b0; Mem_Ready = 1'b0; Zero = 1'b0; Instruction = 32'h0;
        @(posedge clk);
        @(negedge clk);
        // Held in reset: stray readies must not wake anything up.
        for (int i = 0; i < 3; i++) begin
            Instruction = $urandom;
            cyc(1'b1, 1'b1, 18'h0, 1, 4'b0);
            check_val("inst_cnt_rst", inst_cnt, 32'd0);
        end
        rst = 1'b0;

        run_inst(32'h00221821, 0, 0, 1'b0, -1);   // addu
        run_inst(32'h8C220004, 0, 3, 1'b0, -1);   // lw, three memory wait cycles
        run_inst(32'h10220003, 0, 0, 1'b1, -1);   // beq taken
        run_inst(32'h10220003, 1, 0, 1'b0, -1);   // beq not taken
        run_inst(32'h14220003, 0, 0, 1'b0, -1);   // bne taken
        run_inst(32'h00021883, 0, 0, 1'b0, -1);   // sra
        run_inst(32'h3C011234, 2, 0, 1'b0, -1);   // lui
        run_inst(32'h3421FFFF, 0, 0, 1'b0, -1);   // ori
        run_inst(32'hFC000000, 0, 0, 1'b0, -1);   // unsupported opcode
        run_inst(32'h08000010, 0, 0, 1'b0, -1);   // j
        run_inst(32'hAC220004, 0, 0, 1'b0, -1);   // sw, no wait
        run_inst(32'hAC220004, 0, 5, 1'b0, 1);    // sw aborted by reset in MEM

        for (int n = 0; n < 400; n++)
            run_inst(gen_inst(), $urandom_range(0, 2), $urandom_range(0, 3), rb(), -1);
        run_inst(32'h00000000, 0, 0, 1'b0, -1);   // final IF-cycle check of inst_cnt

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
